seg_serial_tx: RTL



---
 rtl/seg_serial_tx_if.sv | 23 ++
 rtl/seg_serial_tx.sv | 113 +++++++++++
 2 files changed

// File: rtl/seg_serial_tx_if.sv
// Parallel-frame handshake and serial display pins between the segment map
// logic and the serial transmitter.
interface seg_serial_tx_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  start;
   logic [DATA_WIDTH-1:0] par_data;
   logic                  busy;
   logic                  done;
   logic                  seg_clk;
   logic                  seg_dt;
   logic                  seg_ld;

   modport master (
      output start, par_data,
      input  busy, done, seg_clk, seg_dt, seg_ld
   );

   modport slave (
      input  start, par_data,
      output busy, done, seg_clk, seg_dt, seg_ld
   );
endinterface

// File: rtl/seg_serial_tx.sv
// Serialises one segment-ordered frame MSB first into a cascaded 7-segment
// shift-register chain, then pulses the latch strobe and reports completion.
module seg_serial_tx #(
   parameter int DATA_WIDTH = 64,
   parameter int CLK_DIV    = 2,
   parameter int CNT_W      = 7
) (
   input  logic             clk,
   input  logic             rst,
   seg_serial_tx_if.slave   bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_WIDTH);

   state_t                state_r;
   logic [DATA_WIDTH-1:0] shreg_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [DIV_W-1:0]      div_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  seg_clk_r;
   logic                  seg_ld_r;
   logic                  phase_end_s;

   assign phase_end_s = (div_r == DIV_LAST);

   // Zeros shift in from the LSB, so the MSB is already 0 in LATCH and IDLE.
   assign bus.seg_dt  = shreg_r[DATA_WIDTH-1];
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.seg_clk = seg_clk_r;
   assign bus.seg_ld  = seg_ld_r;

   // Frame sequencer: capture, bit-timed shifting, latch strobe, done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         shreg_r   <= '0;
         cnt_r     <= '0;
         div_r     <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         seg_clk_r <= 1'b0;
         seg_ld_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               busy_r    <= 1'b0;
               seg_clk_r <= 1'b0;
               seg_ld_r  <= 1'b0;
               if (bus.start) begin
                  shreg_r <= bus.par_data;
                  cnt_r   <= CNT_FULL;
                  div_r   <= '0;
                  busy_r  <= 1'b1;
                  state_r <= SHIFT;
               end else begin
                  div_r <= '0;
               end
            end
            SHIFT: begin
               if (phase_end_s) begin
                  div_r <= '0;
                  if (!seg_clk_r) begin
                     seg_clk_r <= 1'b1;
                  end else begin
                     // Data moves only on the falling edge, giving full setup.
                     seg_clk_r <= 1'b0;
                     shreg_r   <= {shreg_r[DATA_WIDTH-2:0], 1'b0};
                     cnt_r     <= cnt_r - CNT_W'(1);
                     if (cnt_r == CNT_W'(1)) begin
                        seg_ld_r <= 1'b1;
                        state_r  <= LATCH;
                     end else begin
                        seg_ld_r <= 1'b0;
                     end
                  end
               end else begin
                  div_r <= div_r + DIV_W'(1);
               end
            end
            LATCH: begin
               if (phase_end_s) begin
                  div_r    <= '0;
                  seg_ld_r <= 1'b0;
                  busy_r   <= 1'b0;
                  done_r   <= 1'b1;
                  state_r  <= IDLE;
               end else begin
                  div_r <= div_r + DIV_W'(1);
               end
            end
            default: begin
               state_r   <= IDLE;
               shreg_r   <= '0;
               cnt_r     <= '0;
               div_r     <= '0;
               busy_r    <= 1'b0;
               seg_clk_r <= 1'b0;
               seg_ld_r  <= 1'b0;
            end
         endcase
      end
   end
endmodule
